// File: rtl/crg_seq_ctrl.sv
// crg_seq_ctrl: clock-control sequencer for the clock/reset generator.
// Holds the PLL in reset, waits for a stable synchronized lock (with timeout
// and bounded retries), delays the system reset release, then applies clk1
// mux select / clk2 enable requests only after they have been stable.
module crg_seq_ctrl #(
  parameter int PLL_RST_CYC     = 16,
  parameter int LOCK_STABLE_CYC = 64,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int RST_REL_CYC     = 32,
  parameter int MAX_RETRY       = 3,
  parameter int SEL_STABLE_CYC  = 8
) (
  input  logic                                clk_src,
  input  logic                                rst_sys,
  input  logic                                pll_locked,
  input  logic                                clk1_pll_req,
  input  logic                                clk2_en_req,
  output logic                                pll_reset,
  output logic                                clk1_sel,
  output logic                                clk2_cen,
  output logic                                rst_n_sys,
  output logic                                ready,
  output logic                                sel_busy,
  output logic                                lock_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]      retry_cnt
);

  localparam int PCW = $clog2(((PLL_RST_CYC > RST_REL_CYC) ? PLL_RST_CYC : RST_REL_CYC) + 1);
  localparam int SCW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTW = $clog2(MAX_RETRY + 1);
  localparam int SSW = $clog2(SEL_STABLE_CYC + 1);

  localparam logic [PCW-1:0] PRST_LAST = PCW'(PLL_RST_CYC - 1);
  localparam logic [PCW-1:0] REL_LAST  = PCW'(RST_REL_CYC - 1);
  localparam logic [SCW-1:0] STB_MAX   = SCW'(LOCK_STABLE_CYC);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [TCW-1:0] TMO_MAX   = TCW'(LOCK_TIMEOUT);
  localparam logic [RTW-1:0] RETRY_MAX = RTW'(MAX_RETRY);
  localparam logic [SSW-1:0] SST_LAST  = SSW'(SEL_STABLE_CYC - 1);
  localparam logic [SSW-1:0] SST_MAX   = SSW'(SEL_STABLE_CYC);

  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_REL_DLY, S_RUN, S_FAIL
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] cnt_q, cnt_d;     // phase counter for PLL_RST and REL_DLY
  logic [TCW-1:0] tmo_q, tmo_d;     // cycles spent in WAIT_LOCK
  logic [SCW-1:0] stb_q, stb_d;     // consecutive synced-lock cycles
  logic [RTW-1:0] retry_q, retry_d;
  logic           req1_q, req1_d, req2_q, req2_d;  // last sampled requests
  logic [SSW-1:0] sst_q, sst_d;                    // request stability count
  logic           app1_q, app1_d, app2_q, app2_d;  // applied requests
  logic           sync1_q, sync2_q;
  logic           run_d;

  logic pll_reset_q, clk1_sel_q, clk2_cen_q, rst_n_q, ready_q, sel_busy_q, lock_fail_q;

  wire lock_s = sync2_q;
  wire req_same = (clk1_pll_req == req1_q) && (clk2_en_req == req2_q);

  // Lock synchronizer; held clear while the PLL is in reset so lock must be
  // freshly observed after every PLL reset.
  always_ff @(posedge clk_src) begin
    if (rst_sys || pll_reset_q) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counters and applied-request selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    stb_d   = stb_q;
    retry_d = retry_q;
    req1_d  = clk1_pll_req;
    req2_d  = clk2_en_req;
    sst_d   = '0;
    app1_d  = 1'b0;
    app2_d  = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PRST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
          stb_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock acceptance takes priority over a coincident timeout.
        if (stb_q == STB_MAX) begin
          state_d = S_REL_DLY;
          cnt_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_PLL_RST;
            cnt_d   = '0;
          end
        end
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
        if (!lock_s)             stb_d = '0;
        else if (stb_q != STB_MAX) stb_d = stb_q + 1'b1;
      end
      S_REL_DLY: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == REL_LAST) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end else begin
          app1_d = app1_q;
          app2_d = app2_q;
          if (!req_same)              sst_d = '0;
          else if (sst_q == SST_MAX)  sst_d = sst_q;
          else                        sst_d = sst_q + 1'b1;
          // Only one output moves per cycle; clk1 select goes first.
          if (req_same && (sst_q >= SST_LAST)) begin
            if (app1_q != req1_q) app1_d = req1_q;
            else                  app2_d = req2_q;
          end
        end
      end
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_PLL_RST;
    endcase
    run_d = (state_d == S_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk_src) begin
    if (rst_sys) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      stb_q       <= '0;
      retry_q     <= '0;
      req1_q      <= 1'b0;
      req2_q      <= 1'b0;
      sst_q       <= '0;
      app1_q      <= 1'b0;
      app2_q      <= 1'b0;
      pll_reset_q <= 1'b1;
      clk1_sel_q  <= 1'b1;
      clk2_cen_q  <= 1'b0;
      rst_n_q     <= 1'b0;
      ready_q     <= 1'b0;
      sel_busy_q  <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      stb_q       <= stb_d;
      retry_q     <= retry_d;
      req1_q      <= req1_d;
      req2_q      <= req2_d;
      sst_q       <= sst_d;
      app1_q      <= app1_d;
      app2_q      <= app2_d;
      pll_reset_q <= (state_d == S_PLL_RST) || (state_d == S_FAIL);
      clk1_sel_q  <= !(run_d && app1_d);
      clk2_cen_q  <= run_d && app2_d;
      rst_n_q     <= run_d;
      ready_q     <= run_d;
      sel_busy_q  <= run_d && ((clk1_pll_req != app1_d) || (clk2_en_req != app2_d));
      lock_fail_q <= lock_fail_q || (state_d == S_FAIL);
    end
  end

  assign pll_reset = pll_reset_q;
  assign clk1_sel  = clk1_sel_q;
  assign clk2_cen  = clk2_cen_q;
  assign rst_n_sys = rst_n_q;
  assign ready     = ready_q;
  assign sel_busy  = sel_busy_q;
  assign lock_fail = lock_fail_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_crg_seq_ctrl.sv
// tb_crg_seq_ctrl: directed + randomized bench with a phase-level reference model.
module tb_crg_seq_ctrl;
  localparam int PLL_RST_CYC     = 16;
  localparam int LOCK_STABLE_CYC = 64;
  localparam int LOCK_TIMEOUT    = 4096;
  localparam int RST_REL_CYC     = 32;
  localparam int MAX_RETRY       = 3;
  localparam int SEL_STABLE_CYC  = 8;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int VW = 7 + RW;
  localparam logic [VW-1:0] RST_VEC = {1'b1, 1'b1, 5'b0, {RW{1'b0}}};

  localparam int MS_PRST = 0, MS_WAIT = 1, MS_REL = 2, MS_RUN = 3, MS_FAIL = 4;

  logic clk_src = 1'b0;
  logic rst_sys = 1'b1, pll_locked = 1'b0, clk1_pll_req = 1'b0, clk2_en_req = 1'b0;
  logic pll_reset, clk1_sel, clk2_cen, rst_n_sys, ready, sel_busy, lock_fail;
  logic [RW-1:0] retry_cnt;

  crg_seq_ctrl #(
    .PLL_RST_CYC(PLL_RST_CYC), .LOCK_STABLE_CYC(LOCK_STABLE_CYC), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .RST_REL_CYC(RST_REL_CYC), .MAX_RETRY(MAX_RETRY), .SEL_STABLE_CYC(SEL_STABLE_CYC)
  ) dut (
    .clk_src(clk_src), .rst_sys(rst_sys), .pll_locked(pll_locked),
    .clk1_pll_req(clk1_pll_req), .clk2_en_req(clk2_en_req),
    .pll_reset(pll_reset), .clk1_sel(clk1_sel), .clk2_cen(clk2_cen),
    .rst_n_sys(rst_n_sys), .ready(ready), .sel_busy(sel_busy),
    .lock_fail(lock_fail), .retry_cnt(retry_cnt)
  );

  always #5 clk_src = ~clk_src;

  int n_chk = 0, n_err = 0;
  int t_rel = 0;  // edges since rst_sys was last sampled high

  // reference model state
  int m_st = MS_PRST, m_el = 0, m_stb = 0, m_retry = 0, m_rl = 0;
  bit m_fail = 0, m_app1 = 0, m_app2 = 0, m_l1 = 0, m_l2 = 0;
  bit pin_h1 = 0, pin_h2 = 0, prst_h1 = 1, prst_h2 = 1;
  logic [VW-1:0] exp_vec = RST_VEC;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  endtask

  function automatic logic [VW-1:0] outv();
    return {pll_reset, clk1_sel, clk2_cen, rst_n_sys, ready, sel_busy, lock_fail, retry_cnt};
  endfunction

  // One clock edge of the reference model: phases with elapsed-cycle counts,
  // lock seen two edges late unless the PLL was held in reset meanwhile.
  task automatic model_edge();
    bit synced, run, e_prst;
    e_prst = exp_vec[VW-1];
    synced = pin_h2 && !prst_h2 && !prst_h1;
    pin_h2 = pin_h1;  prst_h2 = prst_h1;
    pin_h1 = pll_locked; prst_h1 = rst_sys || e_prst;
    if (rst_sys) begin
      m_st = MS_PRST; m_el = 0; m_stb = 0; m_retry = 0; m_fail = 0;
      m_app1 = 0; m_app2 = 0;
    end else begin
      case (m_st)
        MS_PRST: begin
          m_el++;
          if (m_el == PLL_RST_CYC) begin m_st = MS_WAIT; m_el = 0; m_stb = 0; end
        end
        MS_WAIT: begin
          m_el++;
          if (m_stb >= LOCK_STABLE_CYC) begin
            m_st = MS_REL; m_el = 0;
          end else if (m_el == LOCK_TIMEOUT) begin
            m_retry++;
            if (m_retry > MAX_RETRY) begin m_st = MS_FAIL; m_fail = 1; m_retry = MAX_RETRY; end
            else begin m_st = MS_PRST; m_el = 0; end
          end
          m_stb = synced ? m_stb + 1 : 0;
        end
        MS_REL: begin
          if (!synced) begin m_st = MS_PRST; m_el = 0; end
          else begin
            m_el++;
            if (m_el == RST_REL_CYC) begin
              m_st = MS_RUN; m_app1 = 0; m_app2 = 0;
              m_l1 = clk1_pll_req; m_l2 = clk2_en_req; m_rl = 1;
            end
          end
        end
        MS_RUN: begin
          if (!synced) begin m_st = MS_PRST; m_el = 0; end
          else begin
            if (clk1_pll_req == m_l1 && clk2_en_req == m_l2) m_rl++;
            else begin m_rl = 1; m_l1 = clk1_pll_req; m_l2 = clk2_en_req; end
            if (m_rl > SEL_STABLE_CYC) begin
              if (m_app1 != clk1_pll_req) m_app1 = clk1_pll_req;
              else m_app2 = clk2_en_req;
            end
          end
        end
        default: ;
      endcase
    end
    run = (m_st == MS_RUN);
    exp_vec = {(m_st == MS_PRST) || (m_st == MS_FAIL), !(run && m_app1), run && m_app2,
               run, run, run && ((clk1_pll_req != m_app1) || (clk2_en_req != m_app2)),
               m_fail, RW'(m_retry)};
  endtask

  task automatic step();
    @(posedge clk_src);
    model_edge();
    if (rst_sys) t_rel = 0; else t_rel++;
    @(negedge clk_src);
    chk("outs", outv(), exp_vec);
    if (n_err >= 50) finish_run();
  endtask

  initial begin
    int fall, rise, k, k1, k2, bad, g, gl, prev, nst, fail_t;
    // reset state
    repeat (3) step();
    chk("rst_vals", outv(), RST_VEC);

    // immediate lock
    pll_locked = 1; rst_sys = 0; fall = -1; rise = -1;
    for (int i = 0; i < 400 && rise < 0; i++) begin
      step();
      if (fall < 0 && !pll_reset) fall = t_rel;
      if (rise < 0 && ready) rise = t_rel;
    end
    chk("prst_len", fall, PLL_RST_CYC);
    chk("rdy_lat", rise, PLL_RST_CYC + 2 + LOCK_STABLE_CYC + RST_REL_CYC + 1);
    chk("rdy_rstn", rst_n_sys, 1);
    chk("rdy_retry", retry_cnt, 0);

    // clk1 request 0->1 held
    clk1_pll_req = 1; k = -1;
    for (int i = 1; i <= 20 && k < 0; i++) begin
      step();
      if (i == 1) chk("busy_on", sel_busy, 1);
      if (!clk1_sel) k = i;
    end
    chk("sel_lat", k, SEL_STABLE_CYC + 1);
    repeat (2) step();
    chk("busy_off", sel_busy, 0);

    // short toggles never reach clk1_sel
    bad = 0;
    for (int w = 1; w < SEL_STABLE_CYC; w++) begin
      clk1_pll_req = 0;
      for (int j = 0; j < w; j++) begin step(); bad |= clk1_sel; end
      clk1_pll_req = 1;
      for (int j = 0; j < 3; j++) begin step(); bad |= clk1_sel; end
    end
    chk("short_tgl", bad, 0);
    repeat (12) step();

    // both requests change together
    clk1_pll_req = 0; clk2_en_req = 1; k1 = -1; k2 = -1;
    for (int i = 1; i <= 20 && k2 < 0; i++) begin
      step();
      if (k1 < 0 && clk1_sel) k1 = i;
      if (k2 < 0 && clk2_cen) k2 = i;
    end
    chk("both_clk1", k1, SEL_STABLE_CYC + 1);
    chk("both_clk2", k2, SEL_STABLE_CYC + 2);

    // random request traffic in RUN
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) clk1_pll_req = ~clk1_pll_req;
      if ($urandom_range(0, 5) == 0) clk2_en_req = ~clk2_en_req;
      step();
    end

    // loss of lock in RUN
    clk1_pll_req = 1; clk2_en_req = 1;
    repeat (12) step();
    chk("pre_drop", {clk1_sel, clk2_cen, rst_n_sys}, 3'b011);
    pll_locked = 0; k = -1;
    for (int i = 1; i <= 10 && k < 0; i++) begin step(); if (!rst_n_sys) k = i; end
    chk("drop_lat", k, 3);
    chk("drop_outs", {clk1_sel, clk2_cen, ready, pll_reset}, 4'b1001);
    chk("drop_retry", retry_cnt, 0);

    // relock, then rst_sys in the middle of REL_DLY
    pll_locked = 1;
    repeat (99) step();
    chk("in_rel", {ready, pll_reset, rst_n_sys}, 3'b000);
    rst_sys = 1; step();
    chk("rel_rst", outv(), RST_VEC);

    // single-cycle glitch during the stable count
    g = $urandom_range(1, 60); gl = 19 + g; rst_sys = 0; rise = -1;
    for (int t = 1; t <= 400 && rise < 0; t++) begin
      pll_locked = (t == gl) ? 1'b0 : 1'b1;
      step();
      if (ready) rise = t_rel;
    end
    chk("glitch_rdy", rise, gl + 2 + LOCK_STABLE_CYC + 1 + RST_REL_CYC);

    // lock never comes: retries then FAIL
    rst_sys = 1; pll_locked = 0; step();
    rst_sys = 0; prev = 0; nst = 0; fail_t = -1;
    for (int i = 1; i <= 20000 && fail_t < 0; i++) begin
      step();
      if (retry_cnt != prev[RW-1:0]) begin
        nst++;
        chk("retry_val", retry_cnt, nst);
        chk("retry_t", t_rel, nst * (PLL_RST_CYC + LOCK_TIMEOUT));
        prev = retry_cnt;
      end
      if (lock_fail) fail_t = t_rel;
    end
    chk("retry_n", nst, MAX_RETRY);
    chk("fail_t", fail_t, (MAX_RETRY + 1) * (PLL_RST_CYC + LOCK_TIMEOUT));
    chk("fail_outs", {pll_reset, lock_fail, rst_n_sys, clk1_sel, retry_cnt}, {4'b1101, RW'(MAX_RETRY)});
    pll_locked = 1;
    repeat (200) step();
    chk("fail_hold", {lock_fail, pll_reset, ready}, 3'b110);
    rst_sys = 1; step();
    chk("fail_clr", outv(), RST_VEC);

    // randomized soak: lock drops and request churn
    rst_sys = 0;
    for (int i = 0; i < 4000; i++) begin
      if (pll_locked) begin if ($urandom_range(0, 399) == 0) pll_locked = 0; end
      else if ($urandom_range(0, 19) == 0) pll_locked = 1;
      if ($urandom_range(0, 7) == 0) clk1_pll_req = ~clk1_pll_req;
      if ($urandom_range(0, 7) == 0) clk2_en_req = ~clk2_en_req;
      if ($urandom_range(0, 2999) == 0) rst_sys = 1; else rst_sys = 0;
      step();
    end

    finish_run();
  end
endmodule
